wf_slot_tracker: RTL and testbench
==================================

WF_SLOT_TRACKER -- requirements
Module: wf_slot_tracker

Interface
REQ-001 Parameter NUM_WF, default 40, is the number of wavefront slots tracked.
REQ-002 Parameter WFID_W, default 6, is the width of a wavefront ID.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 alloc_valid  input  1  request to mark slot alloc_wfid busy.
REQ-006 alloc_wfid  input  6  slot ID to allocate.
REQ-007 alloc_ack  output  1  combinational; high in the same cycle as an accepted allocation.
REQ-008 release_valid  input  1  request to mark slot release_wfid free.
REQ-009 release_wfid  input  6  slot ID to release.
REQ-010 drain_req  input  1  level; blocks new allocations and waits for all slots to free.
REQ-011 drain_done  output  1  registered; high while in state DONE.
REQ-012 err_clear  input  1  pulse; clears the sticky error flags.
REQ-013 busy_bitmap  output  40  registered; bit i high = slot i busy.
REQ-014 free_count  output  6  registered; count of zero bits in busy_bitmap, range 0..40.
REQ-015 full / empty  output  1 each  registered; free_count==0 / free_count==40.
REQ-016 err_flags  output  4  sticky; [0] alloc busy slot, [1] alloc ID>=40, [2] release free slot, [3] release ID>=40.

Function
REQ-017 An allocation SHALL be accepted iff alloc_valid, alloc_wfid<40, busy_bitmap[alloc_wfid]==0, and state is IDLE; the bit is set on the next edge.
REQ-018 A release SHALL be accepted iff release_valid, release_wfid<40, and busy_bitmap[release_wfid]==1, in any state; the bit is cleared on the next edge.
REQ-019 Both requests SHALL be evaluated against the current registered bitmap; an accepted alloc and an accepted release of different IDs in one cycle SHALL both take effect.
REQ-020 An alloc and a release of the same busy ID in one cycle: the release SHALL be accepted, the alloc SHALL be rejected with err_flags[0], and the bit SHALL end cleared.
REQ-021 An allocation rejected only because state is not IDLE SHALL NOT set any error flag; alloc_ack SHALL stay low.
REQ-022 Rejected requests SHALL leave busy_bitmap unchanged.
REQ-023 free_count, full and empty SHALL update on the same edge as busy_bitmap (latency 1 cycle from request).
REQ-024 Net free_count change per cycle SHALL be -1, 0 or +1; free_count SHALL never exceed 40 or go below 0.
REQ-025 Error flags SHALL set on the edge after the offending request; if a set and err_clear coincide, the set SHALL win.
REQ-026 FSM states SHALL be IDLE, DRAIN and DONE.
REQ-027 IDLE -> DRAIN on drain_req=1.
REQ-028 DRAIN -> DONE when the next-state bitmap is all-zero, including a release accepted in the same cycle.
REQ-029 DONE -> IDLE on drain_req=0.
REQ-030 DRAIN -> IDLE SHALL occur if drain_req drops before the bitmap empties.
REQ-031 drain_req asserted in IDLE with the bitmap already empty SHALL reach DONE within 2 cycles.

Reset
REQ-032 On rst=1 at a clock edge, the following SHALL take effect on that edge, overriding all inputs: busy_bitmap=0, free_count=40, empty=1, full=0, err_flags=0, state=IDLE, drain_done=0.
REQ-033 alloc_ack SHALL be low while rst=1.
REQ-034 A rst asserted mid-drain SHALL abandon the drain.

Structure
REQ-035 NUM_WF, WFID_W and the FSM state encodings SHALL live in the shared GPU defines include.
REQ-036 The ID-to-one-hot conversion SHALL be one combinational sub-module, decoder_6to40, with input enable and a 40-bit output that is all-zero for IDs >=40 or enable=0.
REQ-037 Two instances of decoder_6to40 SHALL be used, one for alloc and one for release.
REQ-038 free_count SHALL be maintained incrementally, not by re-counting the bitmap.

Verification
REQ-039 Reset, then allocate IDs 0..39 in consecutive cycles -> alloc_ack every cycle; busy_bitmap all ones; free_count=0 and full=1 one cycle after the last allocation.
REQ-040 Allocate 5 twice -> second request gives alloc_ack=0, err_flags=4'b0001 next cycle, bitmap unchanged.
REQ-041 Allocate 41 and release 63 in one cycle -> err_flags=4'b1010 next cycle; err_clear -> err_flags=0 next cycle.
REQ-042 Slot 7 busy; alloc 7 and release 7 in one cycle -> bit 7 ends clear, err_flags[0]=1; then alloc 3 and release 7 in one cycle -> bit 3 set, free_count unchanged.
REQ-043 Slots 2 and 9 busy; drain_req=1; alloc 4 -> rejected, no error; release 2, then 9 -> drain_done=1 on the edge after the release of 9; drain_req=0 -> IDLE, alloc 4 accepted.
REQ-044 rst=1 during DRAIN with 10 slots busy -> next cycle bitmap=0, free_count=40, drain_done=0, state IDLE.

Source files
------------

// File: rtl/wf_slot_tracker_pkg.sv
// Shared definitions for the wavefront slot tracker.
//   NUM_WF  - number of wavefront slots tracked
//   WFID_W  - width of a wavefront ID
//   state_e - drain FSM state encoding
package wf_slot_tracker_pkg;

  localparam int unsigned NUM_WF = 40;
  localparam int unsigned WFID_W = 6;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrain = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/decoder_6to40.sv
// ID to one-hot decoder.
//   en_i     - enable; output is all-zero when low
//   id_i     - slot ID
//   onehot_o - bit id_i set; all-zero when id_i >= NumWf
module decoder_6to40
  import wf_slot_tracker_pkg::*;
#(
  parameter int unsigned NumWf = NUM_WF,
  parameter int unsigned IdW   = WFID_W
) (
  input  logic             en_i,
  input  logic [IdW-1:0]   id_i,
  output logic [NumWf-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < NumWf; i++) begin
      onehot_o[i] = en_i && (id_i == IdW'(i));
    end
  end

endmodule

// File: rtl/wf_slot_tracker.sv
// Wavefront slot tracker: busy bitmap with alloc/release, sticky error flags
// and a drain FSM (IDLE -> DRAIN -> DONE).
//   clk, rst (sync, active-high)
//   alloc_valid/alloc_wfid     -> alloc_ack (combinational)
//   release_valid/release_wfid
//   drain_req (level)          -> drain_done (registered)
//   err_clear (pulse)          -> err_flags (sticky)
//   busy_bitmap, free_count, full, empty (registered)
module wf_slot_tracker
  import wf_slot_tracker_pkg::*;
#(
  parameter int unsigned NUM_WF = wf_slot_tracker_pkg::NUM_WF,
  parameter int unsigned WFID_W = wf_slot_tracker_pkg::WFID_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [WFID_W-1:0] alloc_wfid,
  output logic              alloc_ack,
  input  logic              release_valid,
  input  logic [WFID_W-1:0] release_wfid,
  input  logic              drain_req,
  output logic              drain_done,
  input  logic              err_clear,
  output logic [NUM_WF-1:0] busy_bitmap,
  output logic [WFID_W-1:0] free_count,
  output logic              full,
  output logic              empty,
  output logic [3:0]        err_flags
);

  state_e            state_q, state_d;
  logic [NUM_WF-1:0] busy_q, busy_d;
  logic [WFID_W-1:0] free_q, free_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic [3:0]        err_q, err_d, err_set;

  logic [NUM_WF-1:0] alloc_oh, rel_oh;
  logic              alloc_in_range, alloc_busy, alloc_ok;
  logic              rel_in_range, rel_busy, rel_ok;

  decoder_6to40 #(.NumWf(NUM_WF), .IdW(WFID_W)) u_dec_alloc (
    .en_i     (alloc_valid),
    .id_i     (alloc_wfid),
    .onehot_o (alloc_oh)
  );

  decoder_6to40 #(.NumWf(NUM_WF), .IdW(WFID_W)) u_dec_release (
    .en_i     (release_valid),
    .id_i     (release_wfid),
    .onehot_o (rel_oh)
  );

  // Decoder output is zero for out-of-range IDs, so it doubles as a range check.
  always_comb begin
    alloc_in_range = |alloc_oh;
    alloc_busy     = |(alloc_oh & busy_q);
    rel_in_range   = |rel_oh;
    rel_busy       = |(rel_oh & busy_q);

    alloc_ok = !rst && alloc_in_range && !alloc_busy && (state_q == StIdle);
    rel_ok   = rel_in_range && rel_busy;

    // Alloc and release are both judged against busy_q, so a same-ID pair
    // resolves to "release wins, alloc errors".
    busy_d = busy_q;
    if (alloc_ok) busy_d = busy_d | alloc_oh;
    if (rel_ok)   busy_d = busy_d & ~rel_oh;

    free_d = free_q - WFID_W'(alloc_ok) + WFID_W'(rel_ok);
    full_d  = (free_d == '0);
    empty_d = (free_d == WFID_W'(NUM_WF));

    // A not-IDLE rejection of a free in-range slot raises nothing.
    err_set[0] = alloc_valid && alloc_in_range && alloc_busy;
    err_set[1] = alloc_valid && !alloc_in_range;
    err_set[2] = release_valid && rel_in_range && !rel_busy;
    err_set[3] = release_valid && !rel_in_range;
    err_d = (err_clear ? 4'b0000 : err_q) | err_set;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (drain_req) state_d = StDrain;
      StDrain: begin
        if (!drain_req)           state_d = StIdle;
        else if (busy_d == '0)    state_d = StDone;
      end
      StDone:  if (!drain_req) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      busy_q  <= '0;
      free_q  <= WFID_W'(NUM_WF);
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      free_q  <= free_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      err_q   <= err_d;
    end
  end

  assign alloc_ack   = alloc_ok;
  assign drain_done  = (state_q == StDone);
  assign busy_bitmap = busy_q;
  assign free_count  = free_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign err_flags   = err_q;

endmodule

// File: tb/tb_wf_slot_tracker.sv
module tb_wf_slot_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alloc_valid = 1'b0;
  logic [5:0]  alloc_wfid = '0;
  logic        alloc_ack;
  logic        release_valid = 1'b0;
  logic [5:0]  release_wfid = '0;
  logic        drain_req = 1'b0;
  logic        drain_done;
  logic        err_clear = 1'b0;
  logic [39:0] busy_bitmap;
  logic [5:0]  free_count;
  logic        full;
  logic        empty;
  logic [3:0]  err_flags;

  always #5 clk = ~clk;

  wf_slot_tracker dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_valid   (alloc_valid),
    .alloc_wfid    (alloc_wfid),
    .alloc_ack     (alloc_ack),
    .release_valid (release_valid),
    .release_wfid  (release_wfid),
    .drain_req     (drain_req),
    .drain_done    (drain_done),
    .err_clear     (err_clear),
    .busy_bitmap   (busy_bitmap),
    .free_count    (free_count),
    .full          (full),
    .empty         (empty),
    .err_flags     (err_flags)
  );

  typedef struct packed {
    logic [39:0] busy;
    logic [5:0]  fc;
    logic        full;
    logic        empty;
    logic [3:0]  err;
    logic        done;
  } exp_t;

  exp_t exp_q[$];

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: 0 idle, 1 drain, 2 done
  logic [39:0] m_busy  = '0;
  logic [3:0]  m_err   = '0;
  int          m_state = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic av, input int aid, input logic rv,
                       input int rid, input logic dr, input logic ec);
    logic        a_in, a_busy, r_in, r_busy, ack, r_ok;
    logic [39:0] one, nb;
    logic [3:0]  nset;
    int          ns;
    exp_t        e, got;
    @(negedge clk);
    rst = r; alloc_valid = av; alloc_wfid = 6'(aid);
    release_valid = rv; release_wfid = 6'(rid);
    drain_req = dr; err_clear = ec;
    #1;
    one    = 40'd1;
    a_in   = (aid < 40);
    a_busy = a_in ? m_busy[aid] : 1'b0;
    r_in   = (rid < 40);
    r_busy = r_in ? m_busy[rid] : 1'b0;
    ack    = !r && av && a_in && !a_busy && (m_state == 0);
    r_ok   = rv && r_in && r_busy;
    check("alloc_ack", 64'(alloc_ack), 64'(ack));

    nb = m_busy;
    if (ack)  nb = nb | (one << aid);
    if (r_ok) nb = nb & ~(one << rid);
    nset = {rv && !r_in, rv && r_in && !r_busy, av && !a_in, av && a_in && a_busy};
    ns = m_state;
    case (m_state)
      0: if (dr) ns = 1;
      1: if (!dr) ns = 0; else if (nb == '0) ns = 2;
      default: if (!dr) ns = 0;
    endcase
    if (r) begin
      m_busy = '0; m_err = '0; m_state = 0;
    end else begin
      m_busy = nb; m_err = (ec ? 4'b0 : m_err) | nset; m_state = ns;
    end
    e.busy  = m_busy;
    e.fc    = 6'(40 - $countones(m_busy));
    e.full  = (m_busy == {40{1'b1}});
    e.empty = (m_busy == '0);
    e.err   = m_err;
    e.done  = (m_state == 2);
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check("busy_bitmap", 64'(busy_bitmap), 64'(got.busy));
    check("free_count",  64'(free_count),  64'(got.fc));
    check("full",        64'(full),        64'(got.full));
    check("empty",       64'(empty),       64'(got.empty));
    check("err_flags",   64'(err_flags),   64'(got.err));
    check("drain_done",  64'(drain_done),  64'(got.done));
  endtask

  task automatic idle(input logic dr);
    cycle(1'b0, 1'b0, 0, 1'b0, 0, dr, 1'b0);
  endtask

  task automatic alloc(input int id, input logic dr);
    cycle(1'b0, 1'b1, id, 1'b0, 0, dr, 1'b0);
  endtask

  task automatic rel(input int id, input logic dr);
    cycle(1'b0, 1'b0, 0, 1'b1, id, dr, 1'b0);
  endtask

  task automatic reset_dut();
    // alloc_valid held high: ack must stay low during reset
    cycle(1'b1, 1'b1, 3, 1'b1, 4, 1'b1, 1'b0);
  endtask

  initial begin
    reset_dut();

    // Fill every slot, then full
    for (int i = 0; i < 40; i++) alloc(i, 1'b0);
    check("full_after_fill", 64'(full), 64'd1);
    check("fc_after_fill", 64'(free_count), 64'd0);
    alloc(12, 1'b0);
    reset_dut();

    // Double allocation of 5
    alloc(5, 1'b0);
    alloc(5, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);

    // Out-of-range alloc and release together, then clear
    cycle(1'b0, 1'b1, 41, 1'b1, 63, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);

    // Same-ID alloc+release, then alloc 3 with release 7
    alloc(7, 1'b0);
    cycle(1'b0, 1'b1, 7, 1'b1, 7, 1'b0, 1'b0);
    alloc(7, 1'b0);
    cycle(1'b0, 1'b1, 3, 1'b1, 7, 1'b0, 1'b0);
    // Clear coincides with a new error: set wins
    cycle(1'b0, 1'b1, 45, 1'b0, 0, 1'b0, 1'b1);
    // Release of a free slot
    rel(30, 1'b0);

    // Drain with slots 2 and 9 busy
    reset_dut();
    alloc(2, 1'b0);
    alloc(9, 1'b0);
    idle(1'b1);
    alloc(4, 1'b1);
    rel(2, 1'b1);
    rel(9, 1'b1);
    idle(1'b1);
    idle(1'b0);
    alloc(4, 1'b0);

    // Drain on empty bitmap reaches DONE in two cycles
    reset_dut();
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // Drain abandoned by dropping drain_req
    alloc(1, 1'b0);
    idle(1'b1);
    idle(1'b0);
    alloc(6, 1'b0);

    // Reset during drain
    reset_dut();
    for (int i = 10; i < 20; i++) alloc(i, 1'b0);
    idle(1'b1);
    idle(1'b1);
    reset_dut();
    idle(1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 45),
            $urandom_range(0, 2) == 0, $urandom_range(0, 45),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
